vga_draw_arbiter: RTL

- Shares the single VGA adapter write port (x, y, colour, plot) between NUM_REQ drawing clients, e.g. player erase/redraw and obstacle erase/redraw.
- Each client requests a solid rectangle fill. The block arbitrates round-robin, then scans the granted rectangle one pixel per clock.
- Sits between the game datapath and vga_adapter and replaces ad-hoc per-state pixel counters.

---
 rtl/vga_draw_arbiter.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/vga_draw_arbiter.sv
// Round-robin arbiter that shares the VGA adapter write port and scans each granted rectangle one pixel per clock.
// Optional VGA_DRAW_CLEAR_ON_RESET_EN: clears the full screen to colour 0 after reset before serving requests.
module vga_draw_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int X_MAX   = 160,
  parameter int Y_MAX   = 120
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_x,
  input  logic [7*NUM_REQ-1:0] req_y,
  input  logic [4*NUM_REQ-1:0] req_w,
  input  logic [4*NUM_REQ-1:0] req_h,
  input  logic [3*NUM_REQ-1:0] req_colour,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   done,
  output logic                 busy,
  output logic [7:0]           x,
  output logic [6:0]           y,
  output logic [2:0]           colour,
  output logic                 plot
);

  localparam int PW = $clog2(NUM_REQ);
  localparam logic [8:0] X_LIM = 9'(X_MAX);
  localparam logic [7:0] Y_LIM = 8'(Y_MAX);

`ifdef VGA_DRAW_CLEAR_ON_RESET_EN
  typedef enum logic [1:0] {IDLE, DRAW, FIN, CLEAR} state_t;
  localparam state_t RESET_STATE = CLEAR;
  localparam logic [7:0] X_LAST = 8'(X_MAX - 1);
  localparam logic [6:0] Y_LAST = 7'(Y_MAX - 1);
`else
  typedef enum logic [1:0] {IDLE, DRAW, FIN} state_t;
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t              state, state_d;
  logic [PW-1:0]       rr_ptr, rr_ptr_d;
  logic [PW-1:0]       win, win_d;
  logic [7:0]          x0, x0_d;
  logic [6:0]          y0, y0_d;
  logic [3:0]          w, w_d;
  logic [3:0]          h, h_d;
  logic [2:0]          col, col_d;
  logic [7:0]          cx, cx_d;
  logic [6:0]          cy, cy_d;
  logic [NUM_REQ-1:0]  grant_d, done_d;
  logic                busy_d, plot_d;
  logic [7:0]          x_d;
  logic [6:0]          y_d;
  logic [2:0]          colour_d;

  logic                any_req;
  logic [PW-1:0]       pick;
  logic [8:0]          sum_x;
  logic [7:0]          sum_y;

  assign sum_x = {1'b0, x0} + {1'b0, cx};
  assign sum_y = {1'b0, y0} + {1'b0, cy};

  // First set request at or above the pointer, wrapping around.
  always_comb begin
    int unsigned idx;
    any_req = 1'b0;
    pick    = '0;
    idx     = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        pick    = PW'(idx);
      end
    end
  end

  always_comb begin
    state_d  = state;
    rr_ptr_d = rr_ptr;
    win_d    = win;
    x0_d     = x0;
    y0_d     = y0;
    w_d      = w;
    h_d      = h;
    col_d    = col;
    cx_d     = cx;
    cy_d     = cy;
    grant_d  = grant;
    done_d   = '0;
    busy_d   = busy;
    x_d      = x;
    y_d      = y;
    colour_d = colour;
    plot_d   = 1'b0;

    case (state)
      IDLE: begin
        busy_d = any_req;
        if (any_req) begin
          win_d        = pick;
          x0_d         = req_x[8*int'(pick) +: 8];
          y0_d         = req_y[7*int'(pick) +: 7];
          w_d          = req_w[4*int'(pick) +: 4];
          h_d          = req_h[4*int'(pick) +: 4];
          col_d        = req_colour[3*int'(pick) +: 3];
          cx_d         = '0;
          cy_d         = '0;
          grant_d      = '0;
          grant_d[pick] = 1'b1;
          state_d      = DRAW;
        end
      end

      // Off-screen pixels still take their cycle; only plot is suppressed.
      DRAW: begin
        busy_d   = 1'b1;
        x_d      = sum_x[7:0];
        y_d      = sum_y[6:0];
        colour_d = col;
        plot_d   = (sum_x < X_LIM) && (sum_y < Y_LIM);
        if (cx == {4'b0, w}) begin
          cx_d = '0;
          if (cy == {3'b0, h}) begin
            cy_d    = '0;
            state_d = FIN;
          end else begin
            cy_d = cy + 7'd1;
          end
        end else begin
          cx_d = cx + 8'd1;
        end
      end

      FIN: begin
        busy_d      = 1'b1;
        grant_d     = '0;
        done_d[win] = 1'b1;
        rr_ptr_d    = (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
        state_d     = IDLE;
      end

`ifdef VGA_DRAW_CLEAR_ON_RESET_EN
      CLEAR: begin
        busy_d   = 1'b1;
        grant_d  = '0;
        x_d      = cx;
        y_d      = cy;
        colour_d = '0;
        plot_d   = 1'b1;
        if (cx == X_LAST) begin
          cx_d = '0;
          if (cy == Y_LAST) begin
            cy_d    = '0;
            state_d = IDLE;
          end else begin
            cy_d = cy + 7'd1;
          end
        end else begin
          cx_d = cx + 8'd1;
        end
      end
`endif

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= RESET_STATE;
      rr_ptr <= '0;
      win    <= '0;
      x0     <= '0;
      y0     <= '0;
      w      <= '0;
      h      <= '0;
      col    <= '0;
      cx     <= '0;
      cy     <= '0;
      grant  <= '0;
      done   <= '0;
      busy   <= 1'b0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
      plot   <= 1'b0;
    end else begin
      state  <= state_d;
      rr_ptr <= rr_ptr_d;
      win    <= win_d;
      x0     <= x0_d;
      y0     <= y0_d;
      w      <= w_d;
      h      <= h_d;
      col    <= col_d;
      cx     <= cx_d;
      cy     <= cy_d;
      grant  <= grant_d;
      done   <= done_d;
      busy   <= busy_d;
      x      <= x_d;
      y      <= y_d;
      colour <= colour_d;
      plot   <= plot_d;
    end
  end

endmodule
